// File: rtl/codec_i2s_tx.sv
// rtl/codec_i2s_tx.sv - I2S transmitter for the CS4272 DAC path: clock generation and 16-bit stereo serialization.
// A single 10-bit counter is the timebase; samples enter through a one-entry holding register.
module codec_i2s_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] lft_in,
    input  logic [15:0] rht_in,
    input  logic        smpl_vld,
    output logic        smpl_rdy,
    output logic        MCLK,
    output logic        SCLK,
    output logic        LRCLK,
    output logic        SDin,
    output logic        underrun,
    output logic [7:0]  underrun_cnt
);

    logic [9:0]  cnt;
    logic [9:0]  cnt_nxt;
    logic [15:0] hold_l;
    logic [15:0] hold_r;
    logic        full;
    logic [15:0] sh_l;
    logic [15:0] sh_r;

    logic        frame_start;
    logic        slot_edge;
    logic [4:0]  nxt_slot;
    logic        nxt_right;
    logic        data_slot;
    logic        accept;

    assign cnt_nxt     = cnt + 10'd1;
    assign frame_start = (cnt == 10'd1023);
    assign slot_edge   = (cnt[3:0] == 4'hF);
    assign nxt_slot    = cnt_nxt[8:4];
    assign nxt_right   = cnt_nxt[9];
    assign data_slot   = (nxt_slot >= 5'd1) && (nxt_slot <= 5'd16);
    assign accept      = smpl_vld && !full;

    assign smpl_rdy = !full;
    assign MCLK     = cnt[1];
    assign SCLK     = cnt[3];
    assign LRCLK    = cnt[9];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= 10'd0;
            hold_l       <= 16'd0;
            hold_r       <= 16'd0;
            full         <= 1'b0;
            sh_l         <= 16'd0;
            sh_r         <= 16'd0;
            SDin         <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= 8'd0;
        end else begin
            cnt <= cnt_nxt;

            // accept and drain are exclusive: a drain needs full=1, an accept needs full=0
            if (accept) begin
                hold_l <= lft_in;
                hold_r <= rht_in;
                full   <= 1'b1;
            end else if (frame_start && full) begin
                full <= 1'b0;
            end

            underrun <= 1'b0;
            if (frame_start) begin
                if (full) begin
                    sh_l <= hold_l;
                    sh_r <= hold_r;
                end else begin
                    sh_l     <= 16'd0;
                    sh_r     <= 16'd0;
                    underrun <= 1'b1;
                    if (underrun_cnt != 8'hFF)
                        underrun_cnt <= underrun_cnt + 8'd1;
                end
            end

            // SDin moves on SCLK falling; slot 0 carries the one-bit I2S delay
            if (slot_edge) begin
                if (data_slot) begin
                    if (nxt_right) begin
                        SDin <= sh_r[15];
                        sh_r <= {sh_r[14:0], 1'b0};
                    end else begin
                        SDin <= sh_l[15];
                        sh_l <= {sh_l[14:0], 1'b0};
                    end
                end else begin
                    SDin <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_codec_i2s_tx.sv
// tb/tb_codec_i2s_tx.sv - directed self-checking bench for codec_i2s_tx.
module tb_codec_i2s_tx;

    logic        clk;
    logic        rst;
    logic [15:0] lft_in;
    logic [15:0] rht_in;
    logic        smpl_vld;
    logic        smpl_rdy;
    logic        MCLK;
    logic        SCLK;
    logic        LRCLK;
    logic        SDin;
    logic        underrun;
    logic [7:0]  underrun_cnt;

    int          passed;
    int          total;
    int          c;
    logic        feed;
    logic [15:0] pat;

    codec_i2s_tx dut (
        .clk(clk),
        .rst(rst),
        .lft_in(lft_in),
        .rht_in(rht_in),
        .smpl_vld(smpl_vld),
        .smpl_rdy(smpl_rdy),
        .MCLK(MCLK),
        .SCLK(SCLK),
        .LRCLK(LRCLK),
        .SDin(SDin),
        .underrun(underrun),
        .underrun_cnt(underrun_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        logic acc;
        logic was_rst;
        acc     = smpl_vld && smpl_rdy;
        was_rst = rst;
        @(posedge clk);
        #1;
        if (was_rst) c = 0;
        else c = (c + 1) % 1024;
        if (feed && acc && !was_rst) begin
            pat    = pat + 16'd1;
            lft_in = pat;
            rht_in = ~pat;
        end
    endtask

    task automatic goto(input int target);
        int n;
        n = 0;
        while (c != target && n < 1100) begin
            tick();
            n++;
        end
        total++;
        if (c != target) $display("FAIL goto: c=%0d required %0d", c, target);
        else passed++;
    endtask

    task automatic recv_frame(output logic [15:0] l, output logic [15:0] r, output int bad,
                              output int clk_bad, output int rdy_hi, output logic ur0);
        logic [9:0] cv;
        logic [4:0] slot;
        l = 16'd0; r = 16'd0; bad = 0; clk_bad = 0; rdy_hi = 0;
        ur0 = underrun;
        for (int i = 0; i < 1024; i++) begin
            cv = 10'(c);
            if (MCLK !== cv[1] || SCLK !== cv[3] || LRCLK !== cv[9]) clk_bad++;
            if (smpl_rdy === 1'b1) rdy_hi++;
            if (cv[3:0] == 4'd8) begin
                slot = cv[8:4];
                if (slot >= 5'd1 && slot <= 5'd16) begin
                    if (cv[9]) r = {r[14:0], SDin};
                    else       l = {l[14:0], SDin};
                end else if (SDin !== 1'b0) begin
                    bad++;
                end
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; smpl_vld = 1'b0; lft_in = 16'd0; rht_in = 16'd0; feed = 1'b0; pat = 16'd0;
        tick();
        tick();
        total++;
        if ({MCLK, SCLK, LRCLK, SDin, underrun} !== 5'b0) $display("FAIL reset_pins: got %b required 00000", {MCLK, SCLK, LRCLK, SDin, underrun});
        else passed++;
        total++;
        if (smpl_rdy !== 1'b1) $display("FAIL reset_rdy: got %b required 1", smpl_rdy);
        else passed++;
        total++;
        if (underrun_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d required 0", underrun_cnt);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int e_clk, e_sd, e_ur;
        logic [9:0] cv;
        e_clk = 0; e_sd = 0; e_ur = 0;
        for (int i = 1; i < 1024; i++) begin
            tick();
            cv = 10'(c);
            if (MCLK !== cv[1] || SCLK !== cv[3] || LRCLK !== cv[9]) e_clk++;
            if (SDin !== 1'b0) e_sd++;
            if (underrun !== 1'b0) e_ur++;
        end
        total++;
        if (e_clk != 0) $display("FAIL idle_clocks: %0d bad cycles required 0", e_clk);
        else passed++;
        total++;
        if (e_sd != 0) $display("FAIL idle_sdin: %0d nonzero cycles required 0", e_sd);
        else passed++;
        total++;
        if (e_ur != 0) $display("FAIL idle_underrun_early: %0d pulses required 0", e_ur);
        else passed++;
        tick();
        total++;
        if (underrun !== 1'b1 || LRCLK !== 1'b0) $display("FAIL first_frame_underrun: underrun=%b lrclk=%b required 1 0", underrun, LRCLK);
        else passed++;
        total++;
        if (underrun_cnt !== 8'd1) $display("FAIL first_underrun_cnt: got %0d required 1", underrun_cnt);
        else passed++;
    endtask

    task automatic test_single_pair();
        logic [15:0] l, r;
        int bad, clk_bad, rdy_hi;
        logic ur0;
        lft_in = 16'hA5C3; rht_in = 16'h8001; smpl_vld = 1'b1;
        tick();
        smpl_vld = 1'b0;
        total++;
        if (smpl_rdy !== 1'b0) $display("FAIL single_rdy_drop: got %b required 0", smpl_rdy);
        else passed++;
        goto(0);
        total++;
        if (smpl_rdy !== 1'b1) $display("FAIL single_rdy_rise: got %b required 1", smpl_rdy);
        else passed++;
        recv_frame(l, r, bad, clk_bad, rdy_hi, ur0);
        total++;
        if (l !== 16'hA5C3 || $signed(l) != -23101) $display("FAIL single_left: got %h required a5c3", l);
        else passed++;
        total++;
        if (r !== 16'h8001 || $signed(r) != -32767) $display("FAIL single_right: got %h required 8001", r);
        else passed++;
        total++;
        if (bad != 0 || clk_bad != 0) $display("FAIL single_slots: bad=%0d clk_bad=%0d required 0 0", bad, clk_bad);
        else passed++;
        total++;
        if (ur0 !== 1'b0 || underrun_cnt !== 8'd2) $display("FAIL single_underrun: ur0=%b cnt=%0d required 0 2", ur0, underrun_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] l, r;
        int bad, clk_bad, rdy_hi, errs;
        logic ur0;
        pat = 16'd0; lft_in = 16'd0; rht_in = 16'hFFFF; smpl_vld = 1'b1; feed = 1'b1;
        recv_frame(l, r, bad, clk_bad, rdy_hi, ur0);
        total++;
        if (ur0 !== 1'b1 || l !== 16'd0 || r !== 16'd0) $display("FAIL b2b_lead_frame: ur0=%b l=%h r=%h required 1 0000 0000", ur0, l, r);
        else passed++;
        errs = 0;
        for (int k = 0; k < 8; k++) begin
            recv_frame(l, r, bad, clk_bad, rdy_hi, ur0);
            if (l !== 16'(k) || r !== ~16'(k) || ur0 !== 1'b0 || bad != 0 || clk_bad != 0) begin
                errs++;
                $display("FAIL b2b_frame%0d: l=%h r=%h ur0=%b required %h %h 0", k, l, r, ur0, 16'(k), ~16'(k));
            end
        end
        total++;
        if (errs != 0) $display("FAIL b2b_frames: %0d bad frames required 0", errs);
        else passed++;
        total++;
        if (underrun_cnt !== 8'd2) $display("FAIL b2b_cnt: got %0d required 2", underrun_cnt);
        else passed++;
        feed = 1'b0; smpl_vld = 1'b0;
        recv_frame(l, r, bad, clk_bad, rdy_hi, ur0);
        total++;
        if (l !== 16'd8 || r !== ~16'd8 || ur0 !== 1'b0) $display("FAIL b2b_drain: l=%h r=%h ur0=%b required 0008 fff7 0", l, r, ur0);
        else passed++;
        total++;
        if (underrun !== 1'b1 || underrun_cnt !== 8'd3) $display("FAIL b2b_after_drain: ur=%b cnt=%0d required 1 3", underrun, underrun_cnt);
        else passed++;
    endtask

    task automatic test_frame_start_accept();
        logic [15:0] l, r;
        int bad, clk_bad, rdy_hi;
        logic ur0;
        goto(1023);
        lft_in = 16'h1234; rht_in = 16'hFEDC; smpl_vld = 1'b1;
        tick();
        smpl_vld = 1'b0;
        total++;
        if (underrun !== 1'b1 || smpl_rdy !== 1'b0) $display("FAIL fs_accept_edge: ur=%b rdy=%b required 1 0", underrun, smpl_rdy);
        else passed++;
        recv_frame(l, r, bad, clk_bad, rdy_hi, ur0);
        total++;
        if (l !== 16'd0 || r !== 16'd0 || rdy_hi != 0 || underrun_cnt !== 8'd4) $display("FAIL fs_accept_gap: l=%h r=%h rdy_hi=%0d cnt=%0d required 0000 0000 0 4", l, r, rdy_hi, underrun_cnt);
        else passed++;
        recv_frame(l, r, bad, clk_bad, rdy_hi, ur0);
        total++;
        if (l !== 16'h1234 || r !== 16'hFEDC || ur0 !== 1'b0 || rdy_hi != 1024) $display("FAIL fs_accept_data: l=%h r=%h ur0=%b rdy_hi=%0d required 1234 fedc 0 1024", l, r, ur0, rdy_hi);
        else passed++;
        total++;
        if (underrun_cnt !== 8'd5) $display("FAIL fs_accept_cnt: got %0d required 5", underrun_cnt);
        else passed++;
    endtask

    task automatic test_saturation();
        goto(5);
        force dut.underrun_cnt = 8'd253;
        #1;
        release dut.underrun_cnt;
        goto(0);
        total++;
        if (underrun_cnt !== 8'd254) $display("FAIL sat_254: got %0d required 254", underrun_cnt);
        else passed++;
        tick();
        goto(0);
        total++;
        if (underrun_cnt !== 8'd255) $display("FAIL sat_255: got %0d required 255", underrun_cnt);
        else passed++;
        tick();
        goto(0);
        total++;
        if (underrun_cnt !== 8'd255 || underrun !== 1'b1) $display("FAIL sat_hold: cnt=%0d ur=%b required 255 1", underrun_cnt, underrun);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] l, r;
        int bad, clk_bad, rdy_hi;
        logic ur0;
        tick();
        lft_in = 16'h5555; rht_in = 16'hAAAA; smpl_vld = 1'b1;
        tick();
        smpl_vld = 1'b0;
        goto(300);
        rst = 1'b1;
        tick();
        total++;
        if ({MCLK, SCLK, LRCLK, SDin, underrun} !== 5'b0 || smpl_rdy !== 1'b1 || underrun_cnt !== 8'd0)
            $display("FAIL mid_reset_outputs: pins=%b rdy=%b cnt=%0d required 00000 1 0", {MCLK, SCLK, LRCLK, SDin, underrun}, smpl_rdy, underrun_cnt);
        else passed++;
        rst = 1'b0;
        recv_frame(l, r, bad, clk_bad, rdy_hi, ur0);
        total++;
        if (l !== 16'd0 || r !== 16'd0 || ur0 !== 1'b0 || clk_bad != 0 || rdy_hi != 1024)
            $display("FAIL mid_reset_frame: l=%h r=%h ur0=%b clk_bad=%0d rdy_hi=%0d required 0000 0000 0 0 1024", l, r, ur0, clk_bad, rdy_hi);
        else passed++;
        total++;
        if (underrun !== 1'b1 || underrun_cnt !== 8'd1) $display("FAIL mid_reset_underrun: ur=%b cnt=%0d required 1 1", underrun, underrun_cnt);
        else passed++;
        recv_frame(l, r, bad, clk_bad, rdy_hi, ur0);
        total++;
        if (l !== 16'd0 || r !== 16'd0 || bad != 0) $display("FAIL mid_reset_discard: l=%h r=%h bad=%0d required 0000 0000 0", l, r, bad);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        c      = 0;
        test_reset();
        test_idle();
        test_single_pair();
        test_back_to_back();
        test_frame_start_accept();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/codec_i2s_tx.md
# codec_i2s_tx

Synthesizable I2S transmitter that drives the DAC side of the CS4272 codec: it generates MCLK, SCLK and LRCLK from the system clock and serializes one signed 16-bit left/right sample pair per frame onto SDin. Samples arrive from the equalizer datapath through a single-entry holding register with a valid/ready handshake. The block is the counterpart of the codec model's receive path, which reconstructs aout_lft/aout_rht from these same pins.

## Interface
- No parameters; all divider ratios are fixed.
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- lft_in  in  16  signed left sample, two's complement.
- rht_in  in  16  signed right sample, two's complement.
- smpl_vld  in  1  lft_in/rht_in are valid this cycle.
- smpl_rdy  out  1  holding register is empty; a pair is accepted on any edge where smpl_vld && smpl_rdy.
- MCLK  out  1  clk/4.
- SCLK  out  1  clk/16.
- LRCLK  out  1  clk/1024; 0 = left half-frame, 1 = right half-frame.
- SDin  out  1  serial data to the codec, registered.
- underrun  out  1  one-cycle pulse when a frame starts with the holding register empty.
- underrun_cnt  out  8  saturating count of underrun pulses.

## Operation
- A free-running 10-bit counter cnt (0..1023, wraps) is the only timebase. MCLK = cnt[1], SCLK = cnt[3], LRCLK = cnt[9]. All three are driven directly from register bits, so they are glitch-free.
- Frame start is the edge where cnt becomes 0 (wrap from 1023).
- Holding register (hold_l, hold_r, full):
  - Loaded when smpl_vld && !full; full is set on that edge.
  - smpl_rdy = !full, combinational from the flag.
- Transfer at frame start:
  - If full: hold_l/hold_r are copied into the left/right shift registers and full is cleared.
  - If empty: both shift registers are loaded with 0, underrun pulses, and underrun_cnt increments, saturating at 255.
- Simultaneous accept and transfer: the frame-start transfer uses the holding state as it was before the edge.
  - If full was 0, the pair accepted on the frame-start edge lands in the holding register for the next frame, and the current frame underruns.
  - If full was 1, smpl_rdy was 0, so no accept can occur on that edge.
- Serialization is standard I2S: MSB first, delayed one SCLK from the LRCLK edge. SDin changes only on edges where cnt[3:0] becomes 0, which is SCLK falling; the codec samples on SCLK rising.
  - Slot k = cnt[8:4] (0..31) within each half-frame.
  - Slot 0: 0. Slots 1..16: bits 15..0 of the channel's sample. Slots 17..31: 0.
- Reset (any time, including mid-frame):
  - cnt=0, MCLK=0, SCLK=0, LRCLK=0, SDin=0, full=0, smpl_rdy=1, shift registers=0, underrun=0, underrun_cnt=0.
  - A held sample is discarded.
  - The frame that begins at reset release is not a frame start and never flags underrun.

## Timing
- Let cycle c = cnt value after the edge; the first edge after rst deasserts yields c=1.
- MCLK rises at c=2 and falls at c=4. SCLK rises at c=8 and falls at c=16. LRCLK rises at c=512 and falls at c=0.
- Left channel on SDin: bit 15 during c=16..31, bit 14 during 32..47, …, bit 0 during 256..271. SDin=0 during 0..15 and 272..511.
- Right channel on SDin: bit 15 during 528..543, …, bit 0 during 768..783. SDin=0 during 512..527 and 784..1023.
- Latency:
  - A pair accepted at cycle c in frame n first appears on SDin 16 cycles after the next frame start, provided full was 0 before the accept.
  - smpl_rdy drops the cycle after the accept and rises the cycle after the frame-start edge that consumes the pair.
- underrun is high exactly for the cycle where c=0.
- Sustained throughput is one pair per 1024 clk. smpl_vld may stay high continuously.

## Test plan
- Reset release, no samples -> MCLK/SCLK/LRCLK periods of 4/16/1024 clk; SDin stays 0; first frame start at c=0 after 1024 cycles pulses underrun; underrun_cnt=1.
- Accept lft=16'hA5C3, rht=16'h8001 during frame 0 -> in frame 1, a bench-side I2S receiver sampling on SCLK rising recovers left 0xA5C3 (-23101) and right 0x8001 (-32767); all non-data slots are 0; no underrun.
- smpl_vld held high with an incrementing pattern for 8 frames -> exactly one accept per frame; frames carry 0,1,2,… in order; underrun_cnt unchanged after frame 1.
- Assert smpl_vld only on the frame-start cycle with full=0 -> underrun pulses for that frame; the pair is transmitted in the following frame; smpl_rdy=0 from the next cycle until the following frame start.
- No samples for 300 frames -> underrun_cnt saturates at 255 and does not wrap.
- Assert rst at c=300 with a pair held -> next cycle all outputs are at reset values; the held pair is never transmitted; LRCLK is restarted at 0.
